mmp_iddmm_add3_pipe: RTL and testbench
======================================

Name: mmp_iddmm_add3_pipe

Overview:
- Parametrised pipelined three-operand adder, D = A + B + c, for the IDDMM datapath.
- Generalises the fixed 256+128+1 adder to any AW/BW width and any STAGES segment count.
- Adds a valid/ready handshake with full-pipeline backpressure and exposes the carry-out.
- Sits between the partial-product accumulator and the IDDMM reduction stage.

Parameters:
AW, 256, width of operand A and of result D (bits)
BW, 128, width of operand B; legal range 1..AW; zero-extended to AW
STAGES, 2, pipeline depth = number of carry-propagate segments; legal range 1..8; AW % STAGES == 0
SEG, AW/STAGES, derived localparam, segment width; not overridable

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts operand beat this cycle
a_in  input  AW  operand A
b_in  input  BW  operand B, zero-extended to AW internally
c_in  input  1  carry-in, LSB weight
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
d_out  output  AW  (A + B + c) mod 2^AW
co_out  output  1  bit AW of the full sum (sum < 2^(AW+1) always)
flush  input  1  sync pipeline clear; present only with MMP_ADD3_FLUSH_EN

Behaviour:
- Reset: every valid bit is 0, all data/carry registers are 0; out_valid=0, d_out=0, co_out=0; in_ready=1 once reset is released.
- Front end: a 3:2 compression of A, B_ext and c gives sum vector S and shifted carry vector K = {carry[AW-2:0],1'b0}. The dropped carry[AW-1] is kept as a 1-bit side carry kc.
- Stage k (k = 0..STAGES-1):
  - Adds segment k of S and K, plus the carry registered from stage k-1 (stage 0 carry-in = 0).
  - Registers the SEG-bit result, the segment carry, the already-finished lower segments, and the untouched upper S/K segments (skewed pipeline).
- Last stage: co_out = final segment carry XOR kc. kc and the final segment carry are never both 1 for legal sums.
- Latency: exactly STAGES cycles from the accept cycle (in_valid && in_ready) to out_valid, when there is no stall. Throughput is 1 beat/cycle.
- Advance rule: the pipeline advances when en = !out_valid || out_ready. in_ready = en (combinational).
- On en=0 (stall): every stage register holds, including bubbles. Inputs are ignored and no data is lost or duplicated.
- On en=1: stage valid bits shift. A stage whose input was not valid loads valid=0; its data registers may hold or load and are don't-care.
- d_out and co_out are stable while out_valid=1 && out_ready=0.
- Bubbles do not collapse under stall (global stall, no per-stage ready).
- out_ready may be 1 while out_valid=0; this has no effect beyond en=1.
- Mid-operation reset: all in-flight beats are discarded, and outputs return to reset values asynchronously.
- Wrap-around: d_out is modulo 2^AW; the overflow bit appears only on co_out.
- STAGES=1: a single registered full-width adder; in_ready still follows en.

Optional Feature:
- Macro MMP_ADD3_FLUSH_EN.
- Defined:
  - The flush port exists.
  - flush=1 at a rising edge clears all stage valid bits, regardless of stall. Data registers are don't-care.
  - In the same cycle in_ready is forced to 0, so no beat is accepted.
  - flush has priority over en.
- Undefined: the flush port is absent and the logic is not generated.

Test Plan:
- Default params; A=2^256-1, B=0, c=1, out_ready=1 -> after 2 cycles out_valid=1, d_out=0, co_out=1.
- A=0x1234, B=2^128-1, c=0 -> d_out=2^128+0x1233, co_out=0; latency 2. A=2^128-1, B=1, c=1 -> d_out=2^128+1, checking carry across the segment boundary at bit 128.
- Back-to-back: 8 consecutive beats with A=i, B=i, c=i&1 for i=1..8 -> 8 results in order, d_out=2i+(i&1), on consecutive cycles.
- Backpressure: out_ready=0 for 5 cycles while a result is valid -> d_out held, in_ready=0, nothing is lost; after release, the original sequence resumes intact.
- Reset asserted while 2 beats are in flight -> out_valid=0 immediately; after release, the first new beat emerges at the correct 2-cycle latency.
- AW=64, BW=64, STAGES=4, random beats with random out_ready -> every result matches the golden (a+b+c) including co_out. With MMP_ADD3_FLUSH_EN, flush mid-stream -> no further out_valid for flushed beats.

Source files
------------

// File: rtl/mmp_iddmm_add3_pipe.sv
// mmp_iddmm_add3_pipe: pipelined three-operand adder D = A + B + c.
// A 3:2 compressor front end feeds STAGES carry-propagate segments of
// SEG = AW/STAGES bits each. The pipeline is skewed: stage k resolves
// segment k and carries the finished lower segments and the still-unused
// upper S/K segments forward. One global enable stalls every stage at once.
// Optional synchronous flush port: define MMP_ADD3_FLUSH_EN.
module mmp_iddmm_add3_pipe #(
  parameter int AW     = 256,
  parameter int BW     = 128,
  parameter int STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] a_in,
  input  logic [BW-1:0] b_in,
  input  logic          c_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] d_out,
  output logic          co_out
`ifdef MMP_ADD3_FLUSH_EN
  ,
  input  logic          flush
`endif
);

  localparam int SEG = AW / STAGES;

  logic          en;
  logic          flush_w;
  logic [AW-1:0] b_ext;
  logic [AW-1:0] c_ext;
  logic [AW-1:0] s_fe;
  logic [AW-1:0] cy_fe;
  logic [AW-1:0] k_fe;
  logic          kc_fe;

`ifdef MMP_ADD3_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign en       = !out_valid || out_ready;
  assign in_ready = en && !flush_w;

  // 3:2 compression; the carry out of bit AW-1 is kept aside as kc
  assign b_ext = AW'(b_in);
  assign c_ext = AW'(c_in);
  assign s_fe  = a_in ^ b_ext ^ c_ext;
  assign cy_fe = (a_in & b_ext) | (a_in & c_ext) | (b_ext & c_ext);
  assign k_fe  = {cy_fe[AW-2:0], 1'b0};
  assign kc_fe = cy_fe[AW-1];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    // K bits still needed by later stages after this one
    localparam int KW = AW - (g + 1) * SEG;

    logic [AW-1:0]  s_in;
    logic [AW-1:0]  s_d;
    logic [AW-1:0]  s_q;
    logic [SEG-1:0] k_seg;
    logic [SEG:0]   seg_sum;
    logic           c_prev;
    logic           kc_in;
    logic           v_in;
    logic           vld_d;
    logic           vld_q;
    logic           cy_q;
    logic           kc_q;

    if (g == 0) begin : g_src
      assign s_in   = s_fe;
      assign k_seg  = k_fe[SEG-1:0];
      assign c_prev = 1'b0;
      assign kc_in  = kc_fe;
      assign v_in   = in_valid;
    end else begin : g_src
      assign s_in   = g_stage[g-1].s_q;
      assign k_seg  = g_stage[g-1].g_k.k_q[SEG-1:0];
      assign c_prev = g_stage[g-1].cy_q;
      assign kc_in  = g_stage[g-1].kc_q;
      assign v_in   = g_stage[g-1].vld_q;
    end

    if (KW > 0) begin : g_k
      logic [KW-1:0] k_d;
      logic [KW-1:0] k_q;

      if (g == 0) begin : g_ksrc
        assign k_d = k_fe[AW-1:SEG];
      end else begin : g_ksrc
        assign k_d = g_stage[g-1].g_k.k_q[AW-g*SEG-1:SEG];
      end

      // Upper K segments ride along untouched until their own stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  k_q <= '0;
        else if (en) k_q <= k_d;
      end
    end

    assign seg_sum = {1'b0, s_in[g*SEG +: SEG]} + {1'b0, k_seg} + {{SEG{1'b0}}, c_prev};

    // Resolve this stage's segment; finished and pending bits pass through
    always_comb begin
      s_d                 = s_in;
      s_d[g*SEG +: SEG]   = seg_sum[SEG-1:0];
    end

    assign vld_d = flush_w ? 1'b0 : (en ? v_in : vld_q);

    // Stage register: valid follows flush/enable, data advances only on enable
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        s_q   <= '0;
        cy_q  <= 1'b0;
        kc_q  <= 1'b0;
      end else begin
        vld_q <= vld_d;
        if (en) begin
          s_q  <= s_d;
          cy_q <= seg_sum[SEG];
          kc_q <= kc_in;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign d_out     = g_stage[STAGES-1].s_q;
  // The final segment carry and kc cannot both be set for a legal sum
  assign co_out    = g_stage[STAGES-1].cy_q ^ g_stage[STAGES-1].kc_q;

endmodule

// File: tb/tb_mmp_iddmm_add3_pipe.sv
// Bench for mmp_iddmm_add3_pipe: a default-parameter instance driven with
// directed beats, and an AW=64/STAGES=4 instance driven with random beats
// and random out_ready. Expected sums go into per-instance queues on accept
// and are compared when results leave the pipeline.
module tb_mmp_iddmm_add3_pipe;

  localparam int AW_X = 256, BW_X = 128, ST_X = 2;
  localparam int AW_Y = 64,  BW_Y = 64,  ST_Y = 4;

  typedef struct packed {
    logic [256:0] exp;
    int unsigned  stamp;
  } sb_t;

  logic clk, rst_n;

  logic            x_in_valid, x_in_ready, x_c, x_out_valid, x_out_ready, x_co_out;
  logic [AW_X-1:0] x_a, x_d_out;
  logic [BW_X-1:0] x_b;

  logic            y_in_valid, y_in_ready, y_c, y_out_valid, y_out_ready, y_co_out, y_flush;
  logic [AW_Y-1:0] y_a, y_d_out;
  logic [BW_Y-1:0] y_b;

  int n_chk = 0;
  int n_pass = 0;
  int unsigned en_x = 0, en_y = 0;
  sb_t q_x[$];
  sb_t q_y[$];
  sb_t ent_x, ent_y;

  mmp_iddmm_add3_pipe #(.AW(AW_X), .BW(BW_X), .STAGES(ST_X)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(x_in_valid), .in_ready(x_in_ready),
    .a_in(x_a), .b_in(x_b), .c_in(x_c),
    .out_valid(x_out_valid), .out_ready(x_out_ready),
    .d_out(x_d_out), .co_out(x_co_out)
`ifdef MMP_ADD3_FLUSH_EN
    , .flush(1'b0)
`endif
  );

  mmp_iddmm_add3_pipe #(.AW(AW_Y), .BW(BW_Y), .STAGES(ST_Y)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(y_in_valid), .in_ready(y_in_ready),
    .a_in(y_a), .b_in(y_b), .c_in(y_c),
    .out_valid(y_out_valid), .out_ready(y_out_ready),
    .d_out(y_d_out), .co_out(y_co_out)
`ifdef MMP_ADD3_FLUSH_EN
    , .flush(y_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [256:0] obs, input logic [256:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Scoreboard for the default instance
  always @(negedge clk) begin
    if (rst_n) begin
      check("X_in_ready", 257'(x_in_ready), 257'(!x_out_valid || x_out_ready));
      if (x_out_valid) begin
        if (q_x.size() == 0) check("X_spurious_valid", 257'(x_out_valid), 257'(0));
        else if (x_out_ready) begin
          ent_x = q_x.pop_front();
          check("X_result", {x_co_out, x_d_out}, ent_x.exp);
          check_i("X_latency", int'(en_x - ent_x.stamp), ST_X - 1);
        end else check("X_hold", {x_co_out, x_d_out}, q_x[0].exp);
      end
      if (x_in_valid && x_in_ready) begin
        ent_x.exp   = 257'({1'b0, x_a}) + 257'(x_b) + 257'(x_c);
        ent_x.stamp = en_x + 1;
        q_x.push_back(ent_x);
      end
      if (!x_out_valid || x_out_ready) en_x++;
    end
  end

  // Scoreboard for the 64-bit, 4-stage instance
  always @(negedge clk) begin
    if (rst_n) begin
      check("Y_in_ready", 257'(y_in_ready), 257'((!y_out_valid || y_out_ready) && !y_flush));
      if (y_out_valid) begin
        if (q_y.size() == 0) check("Y_spurious_valid", 257'(y_out_valid), 257'(0));
        else if (y_out_ready) begin
          ent_y = q_y.pop_front();
          check("Y_result", 257'({y_co_out, y_d_out}), ent_y.exp);
          check_i("Y_latency", int'(en_y - ent_y.stamp), ST_Y - 1);
        end else check("Y_hold", 257'({y_co_out, y_d_out}), q_y[0].exp);
      end
      if (y_in_valid && y_in_ready) begin
        ent_y.exp   = 257'({1'b0, y_a}) + 257'(y_b) + 257'(y_c);
        ent_y.stamp = en_y + 1;
        q_y.push_back(ent_y);
      end
      if (y_flush) q_y.delete();
      if (!y_out_valid || y_out_ready) en_y++;
    end
  end

  task automatic send_x(input logic [AW_X-1:0] a, input logic [BW_X-1:0] b, input logic c);
    logic acc;
    acc = 1'b0;
    x_in_valid = 1'b1;
    x_a = a;
    x_b = b;
    x_c = c;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      acc = x_in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("X_send_timeout", 257'(acc), 257'(1));
    x_in_valid = 1'b0;
  endtask

  task automatic drain_x();
    for (int i = 0; i < 100; i++) begin
      if (q_x.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check_i("X_drain", q_x.size(), 0);
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    logic y_acc;
    int   issued;
    rst_n = 1'b0;
    x_in_valid = 1'b0; x_a = '0; x_b = '0; x_c = 1'b0; x_out_ready = 1'b1;
    y_in_valid = 1'b0; y_a = '0; y_b = '0; y_c = 1'b0; y_out_ready = 1'b1;
    y_flush = 1'b0;

    #1;
    check("X_rst_out_valid", 257'(x_out_valid), 257'(0));
    check("X_rst_d_co", {x_co_out, x_d_out}, 257'(0));
    check("Y_rst_out_valid", 257'(y_out_valid), 257'(0));
    check("Y_rst_d_co", 257'({y_co_out, y_d_out}), 257'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("X_ready_after_rst", 257'(x_in_ready), 257'(1));
    check("Y_ready_after_rst", 257'(y_in_ready), 257'(1));
    @(posedge clk);
    #1;

    // Full wrap: all-ones + 0 + 1 gives d=0, co=1
    send_x({AW_X{1'b1}}, '0, 1'b1);
    drain_x();

    // Carries across the segment boundary at bit 128
    send_x(256'h1234, {BW_X{1'b1}}, 1'b0);
    send_x({128'h0, {128{1'b1}}}, 128'h1, 1'b1);
    drain_x();

    // Eight back-to-back beats
    for (int i = 1; i <= 8; i++) send_x(AW_X'(i), BW_X'(i), 1'(i & 1));
    drain_x();

    // Backpressure: hold the first result for 5 cycles with a beat waiting
    send_x(256'hAAAA_0001, 128'h10, 1'b1);
    send_x({AW_X{1'b1}}, {BW_X{1'b1}}, 1'b1);
    x_out_ready = 1'b0;
    x_in_valid = 1'b1;
    x_a = 256'h3;
    x_b = 128'h4;
    x_c = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    x_out_ready = 1'b1;
    send_x(256'h3, 128'h4, 1'b0);
    send_x({255'h0, 1'b1} << 200, 128'hFFFF, 1'b1);
    drain_x();

    // Reset with two beats in flight
    send_x(256'h55, 128'h66, 1'b1);
    send_x(256'h77, 128'h88, 1'b0);
    check("X_pre_rst_valid", 257'(x_out_valid), 257'(1));
    #2 rst_n = 1'b0;
    #1;
    check("X_mid_rst_out_valid", 257'(x_out_valid), 257'(0));
    check("X_mid_rst_d_co", {x_co_out, x_d_out}, 257'(0));
    q_x.delete();
    q_y.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_x(256'h1000, 128'h2000, 1'b1);
    drain_x();

    // Random beats with random out_ready on the 64-bit instance
    y_acc = 1'b0;
    issued = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      y_out_ready = ($urandom_range(0, 3) != 0);
      if (!y_in_valid || y_acc) begin
        if (issued >= 150) break;
        if ($urandom_range(0, 3) != 0) begin
          y_in_valid = 1'b1;
          y_a = rnd64();
          y_b = rnd64();
          y_c = 1'($urandom());
          issued++;
        end else y_in_valid = 1'b0;
      end
`ifdef MMP_ADD3_FLUSH_EN
      y_flush = (cyc == 200);
`endif
      @(negedge clk);
      y_acc = y_in_valid && y_in_ready;
      @(posedge clk);
      #1;
    end
    check_i("Y_issued", issued, 150);
    y_in_valid = 1'b0;
    y_flush = 1'b0;
    y_out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (q_y.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check_i("Y_drain", q_y.size(), 0);
    repeat (ST_Y + 2) @(posedge clk);
    #1;
    check("X_idle_valid", 257'(x_out_valid), 257'(0));
    check("Y_idle_valid", 257'(y_out_valid), 257'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
